// File: rtl/memi_pkg.sv
// rtl/memi_pkg.sv - shared types and constants for the mem_initiator16b burst initiator
// Contents: state enum, ADDR_W/DATA_W defaults, read-buffer depth, read latency.
// Option: MEMI_RDBUF_EN selects a 4-deep read buffer (1 word/cycle reads);
// undefined gives a 1-deep buffer with a single read in flight.
package memi_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

`ifdef MEMI_RDBUF_EN
    localparam int RD_BUF_DEPTH = 4;
`else
    localparam int RD_BUF_DEPTH = 1;
`endif

    // Cycles from a read appearing on the pins to the buffer capturing it.
    localparam int RD_LAT = 2;

    // Occupancy count must be able to represent a completely full buffer.
    localparam int CNT_W = $clog2(RD_BUF_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_initiator16b_if.sv
// rtl/mem_initiator16b_if.sv - command, data-stream, status and memory-pin bundle
// master: client side (drives command, write stream, rd_ready, memory data_out).
// slave:  initiator side (drives ready/valid responses, status, memory pins).
interface mem_initiator16b_if;
    import memi_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
               rd_ready, mem_data_out,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
               mem_rw, mem_add, mem_data_in
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
               rd_ready, mem_data_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
               mem_rw, mem_add, mem_data_in
    );

endinterface

// File: rtl/memi_rdbuf.sv
// rtl/memi_rdbuf.sv - read-data FIFO of RD_BUF_DEPTH words with valid/ready pop
// Ports: clk, rst_n (async active-low), push_i/push_data_i (write side),
// pop_valid_o/pop_ready_i/pop_data_o (read stream), count_o (occupancy).
module memi_rdbuf
    import memi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              pop_valid_o,
    input  logic              pop_ready_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RD_BUF_DEPTH - 1);

    // Sized to the pointer range so every pointer value indexes a real entry.
    logic [DATA_W-1:0] buf_q [2**PTR_W];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_valid_o = (count_q != '0);
    assign pop_data_o  = buf_q[rd_ptr_q];
    assign count_o     = count_q;
    assign pop         = pop_valid_o && pop_ready_i;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**PTR_W; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                buf_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_initiator16b.sv
// rtl/mem_initiator16b.sv - burst initiator driving a 16-bit single-port memory
// Ports: clk, rst_n (async active-low), bus (mem_initiator16b_if.slave) carrying
// the command port, write stream, read stream, busy/done and the memory pins.
// Option: MEMI_RDBUF_EN (read-buffer depth, see memi_pkg).
module mem_initiator16b
    import memi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mem_initiator16b_if.slave bus
);
    localparam int CRED_W = CNT_W + 2;

    state_t            state_q, state_d;
    logic              alive_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   beats_q, beats_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_add_q, mem_add_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic              issue;
    logic              last_beat;
    logic              rb_valid, rb_pop;
    logic [DATA_W-1:0] rb_data;
    logic [CNT_W-1:0]  rb_count;
    logic [CRED_W-1:0] in_flight, committed;
    logic              credit_ok;

    // The oldest tag bit lines up with the cycle in which mem_data_out holds
    // the word of a read we issued.
    memi_rdbuf u_rdbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (tag_q[RD_LAT-1]),
        .push_data_i (bus.mem_data_out),
        .pop_valid_o (rb_valid),
        .pop_ready_i (bus.rd_ready),
        .pop_data_o  (rb_data),
        .count_o     (rb_count)
    );

    assign rb_pop    = rb_valid && bus.rd_ready;
    assign last_beat = (beats_q == (ADDR_W+1)'(1));

    // A word popped this cycle frees its slot for a read issued this cycle,
    // which is what gives the 1-deep build its 3-cycle read cadence.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + CRED_W'(tag_q[i]);
        end
        committed = in_flight + CRED_W'(rb_count) - CRED_W'(rb_pop);
        credit_ok = (committed < CRED_W'(RD_BUF_DEPTH));
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beats_d       = beats_q;
        mem_rw_d      = 1'b1;
        mem_add_d     = mem_add_q;
        mem_data_in_d = mem_data_in_q;
        issue         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && alive_q) begin
                    addr_d  = bus.cmd_addr;
                    beats_d = {1'b0, bus.cmd_len} + (ADDR_W+1)'(1);
                    state_d = bus.cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (bus.wr_valid) begin
                    mem_rw_d      = 1'b0;
                    mem_add_d     = addr_q;
                    mem_data_in_d = bus.wr_data;
                    addr_d        = addr_q + ADDR_W'(1);
                    beats_d       = beats_q - (ADDR_W+1)'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue     = 1'b1;
                    mem_add_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    beats_d   = beats_q - (ADDR_W+1)'(1);
                    if (last_beat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final word is handed over, not a cycle later.
                if ((tag_q == '0) && (rb_count == CNT_W'(rb_pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        tag_d = {tag_q[RD_LAT-2:0], issue};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            alive_q       <= 1'b0;
            addr_q        <= '0;
            beats_q       <= '0;
            mem_rw_q      <= 1'b1;
            mem_add_q     <= '0;
            mem_data_in_q <= '0;
            tag_q         <= '0;
        end else begin
            state_q       <= state_d;
            alive_q       <= 1'b1;
            addr_q        <= addr_d;
            beats_q       <= beats_d;
            mem_rw_q      <= mem_rw_d;
            mem_add_q     <= mem_add_d;
            mem_data_in_q <= mem_data_in_d;
            tag_q         <= tag_d;
        end
    end

    assign bus.cmd_ready   = alive_q && (state_q == S_IDLE);
    assign bus.wr_ready    = (state_q == S_WRITE);
    assign bus.rd_valid    = rb_valid;
    assign bus.rd_data     = rb_data;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.mem_rw      = mem_rw_q;
    assign bus.mem_add     = mem_add_q;
    assign bus.mem_data_in = mem_data_in_q;

endmodule

// File: doc/mem_initiator16b.md
# mem_initiator16b

Burst initiator that drives the 16-bit single-port memory's `rw`/`add`/`data_in` pins and collects `data_out`.
- Accepts one command at a time (direction, base address, length) on a valid/ready port.
- Write bursts consume a valid/ready write-data stream; read bursts produce a valid/ready read-data stream with backpressure.
- Sits between any client (DMA, test sequencer, CPU bridge) and the memory array; it is the only master of the memory pins.

## Interface
- `ADDR_W`, 16, address width; memory pins and `cmd_addr`.
- `DATA_W`, 16, data width; memory data and both streams.
- `clk` in 1, single clock; memory shares it.
- `rst_n` in 1, reset, asynchronous, active-low.
- `cmd_valid` in 1, command offered.
- `cmd_ready` out 1, command accepted when both high.
- `cmd_write` in 1, 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W, base word address.
- `cmd_len` in ADDR_W, beats minus one (0 = 1 beat, 0xFFFF = 65536 beats).
- `wr_valid` / `wr_ready` / `wr_data` in / out / in DATA_W, write stream.
- `rd_valid` / `rd_ready` / `rd_data` out / in / out DATA_W, read stream.
- `busy` out 1, high from command accept through `done`.
- `done` out 1, one-cycle pulse at burst end.
- `mem_rw` out 1, to memory `rw`; 1 = read, 0 = write.
- `mem_add` out ADDR_W, to memory `add`.
- `mem_data_in` out DATA_W, to memory `data_in`.
- `mem_data_out` in DATA_W, from memory `data_out`.

## Operation
- **Reset values:**
  - `cmd_ready`, `wr_ready`, `rd_valid`, `busy`, `done` = 0.
  - `rd_data`, `mem_add`, `mem_data_in` = 0.
  - `mem_rw` = 1, so an idle bus is a harmless read.
- **States:** IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE:** `cmd_ready` = 1. On handshake:
  - latch address, beat counter and direction;
  - go to WRITE or READ; `busy` rises in the next cycle.
- **WRITE:**
  - `wr_ready` = 1.
  - Each accepted beat registers `mem_rw` = 0, `mem_add` = current address, `mem_data_in` = `wr_data`, then increments the address.
  - Cycles with no beat register `mem_rw` = 1.
  - Last beat accepted → DONE.
- **READ:**
  - Issues one read per cycle (`mem_rw` = 1, `mem_add` = address) while in-flight plus buffered reads < `RD_BUF_DEPTH`.
  - A shift-register valid tag marks the cycle in which `mem_data_out` belongs to an issued read; that data is pushed into the read buffer.
  - Last read issued → DRAIN.
- **DRAIN:** wait until nothing is in flight and the buffer is empty → DONE.
- **DONE:** `done` = 1 for one cycle, `cmd_ready` = 0 → IDLE.
- **Address arithmetic:** modulo 2^ADDR_W; 0xFFFF increments to 0x0000. No error is raised.
- **Beat counter:** ADDR_W+1 bits, so 65536-beat bursts are legal.
- **Stream independence:** `rd_ready` is ignored outside READ/DRAIN; `wr_valid` is ignored outside WRITE.
- **Reset mid-burst:** aborts immediately (asynchronous).
  - Memory pins return to `mem_rw` = 1.
  - A write beat on the pins but not yet clocked is lost.
  - The read buffer is emptied.

## Timing
- **Write path:** beat accepted at edge N → pins driven during cycle N+1 → memory commits at edge N+2.
- **Write done:** `done` is high in the cycle the last write is on the pins. A following command cannot reach the pins before that write commits.
- **Read path:** read presented in cycle C → memory updates `mem_data_out` at the end of C → buffer captures at the end of C+1 → `rd_valid` high in cycle C+2 at the earliest.
- **Read stream rule:** `rd_data` stays stable while `rd_valid` && !`rd_ready`.
- **Read done:** `done` comes the cycle after the last read-stream handshake.
- **Command spacing:** back-to-back commands are separated by the DONE cycle plus one IDLE cycle.

## Configuration
- **`MEMI_RDBUF_EN` defined:**
  - `RD_BUF_DEPTH` = 4.
  - Read throughput is 1 word/cycle when `rd_ready` stays high.
- **`MEMI_RDBUF_EN` undefined:**
  - `RD_BUF_DEPTH` = 1.
  - Only one read is in flight at a time; the next read issues in the cycle after the buffered word is taken, giving 1 word per 3 cycles.
- **Both builds:** write behaviour is identical.

## Structure
- **`memi_pkg`:**
  - state enum;
  - `ADDR_W`/`DATA_W` defaults;
  - `RD_BUF_DEPTH` chosen under `MEMI_RDBUF_EN`;
  - read-latency constant (2).
- **Sub-module `memi_rdbuf`:**
  - synchronous FIFO of `RD_BUF_DEPTH` × DATA_W with valid/ready pop;
  - exposes an occupancy count for the issue-credit check.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs at reset values and `mem_rw` = 1; release → `cmd_ready` = 1 next cycle.
- **Write burst:**
  - Stimulus: write, addr 0x0010, `cmd_len` = 3, data 0xA0..0xA3, `wr_valid` held high.
  - Response: `mem_rw` = 0 for 4 consecutive cycles at 0x0010..0x0013; one `done` pulse.
- **Read back:**
  - Stimulus: read, 0x0010, len 3, `rd_ready` = 1.
  - Response: `rd_data` 0xA0..0xA3 in order; first `rd_valid` 2 cycles after the first read on the pins.
  - With the macro: the remaining words come on consecutive cycles. Without it: 3-cycle spacing.
- **Wrap-around:**
  - Stimulus: write at 0xFFFE, len 2, data 1, 2, 3.
  - Response: pin addresses 0xFFFE, 0xFFFF, 0x0000. Reading back at 0xFFFE returns 1, 2, 3.
- **Backpressure:**
  - Stimulus: read 8 words with `rd_ready` high 1 cycle in 3.
  - Response: no word lost or duplicated; in-flight plus buffered never exceeds `RD_BUF_DEPTH`; `done` after the 8th handshake.
- **Reset mid-write:**
  - Stimulus: `rst_n` low after 2 of 4 beats accepted.
  - Response: `mem_rw` = 1 in the same cycle; only committed beats are present in memory; the next command is accepted normally.
